core_boot_loader: RTL

- Synthesizable boot sequencer that sits directly upstream of core_flattened and drives its net_packet_flat_i.
- On start_i it reads the instruction ROM and the register-init ROM, then emits a contiguous packet stream: INSTR packets, REG packets, one BAR packet and one PC packet.
- It then holds a NULL packet so the core runs undisturbed.
- It replaces any bench-driven packet injection for FPGA/gate-level boot.

---
 rtl/core_boot_loader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/core_boot_loader.sv
// Boot sequencer feeding core_flattened: streams INSTR, REG, BAR and PC packets
// from two synchronous ROMs, then parks the network input on an idle NULL packet.

package core_boot_loader_pkg;

  typedef enum logic [2:0] {
    NET_OP_NULL  = 3'd0,
    NET_OP_INSTR = 3'd1,
    NET_OP_REG   = 3'd2,
    NET_OP_BAR   = 3'd3,
    NET_OP_PC    = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [9:0]  id;
    net_op_e     net_op;
    logic [4:0]  reserved;
    logic [31:0] net_data;
    logic [9:0]  net_addr;
  } net_packet_s;

  localparam int PACKET_W = $bits(net_packet_s);

endpackage

module core_boot_loader
  import core_boot_loader_pkg::*;
#(
  parameter int          INSTR_COUNT = 1024,
  parameter int          REG_COUNT   = 64,
  parameter logic [9:0]  CORE_ID     = 10'd1,
  parameter logic [31:0] BAR_MASK    = 32'h2,
  parameter logic [9:0]  BAR_ADDR    = 10'd24,
  parameter logic [31:0] START_PC    = 32'h5,
  parameter logic [31:0] IDLE_DATA   = 32'hFFFFFFFE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  output logic [9:0]          instr_addr_o,
  input  logic [15:0]         instr_data_i,
  output logic [5:0]          reg_addr_o,
  input  logic [39:0]         reg_data_i,
  output logic [PACKET_W-1:0] net_packet_flat_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_INSTR, S_REG, S_BAR, S_PC, S_DONE
  } state_e;

  // What the issue stage produced last cycle; travels alongside the ROM latency.
  typedef enum logic [2:0] {
    TAG_NONE, TAG_INSTR, TAG_REG, TAG_BAR, TAG_PC, TAG_IDLE
  } tag_e;

  localparam logic [9:0] INSTR_LAST = 10'(INSTR_COUNT - 1);
  localparam logic [5:0] REG_LAST   = 6'(REG_COUNT - 1);

  state_e      r_state;
  state_e      w_stateNext;
  logic [9:0]  r_instrCnt;
  logic [5:0]  r_regCnt;
  tag_e        r_tagOp;
  tag_e        w_tagNext;
  logic [9:0]  r_tagIdx;
  net_packet_s r_packet;
  net_packet_s w_packetNext;
  logic        r_busy;
  logic        r_done;
  logic        w_unusedRegBits;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_tagNext   = TAG_NONE;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_stateNext = S_INSTR;
        end
      end
      S_INSTR: begin
        w_tagNext = TAG_INSTR;
        if (r_instrCnt == INSTR_LAST) begin
          w_stateNext = S_REG;
        end
      end
      S_REG: begin
        w_tagNext = TAG_REG;
        if (r_regCnt == REG_LAST) begin
          w_stateNext = S_BAR;
        end
      end
      S_BAR: begin
        w_tagNext   = TAG_BAR;
        w_stateNext = S_PC;
      end
      S_PC: begin
        w_tagNext   = TAG_PC;
        w_stateNext = S_DONE;
      end
      S_DONE: begin
        w_tagNext = TAG_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Counters saturate at their last index so the ROM addresses hold afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instrCnt <= '0;
      r_regCnt   <= '0;
    end else begin
      if (r_state == S_INSTR && r_instrCnt != INSTR_LAST) begin
        r_instrCnt <= r_instrCnt + 10'd1;
      end
      if (r_state == S_REG && r_regCnt != REG_LAST) begin
        r_regCnt <= r_regCnt + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tagOp  <= TAG_NONE;
      r_tagIdx <= '0;
    end else begin
      r_tagOp  <= w_tagNext;
      r_tagIdx <= r_instrCnt;
    end
  end

  always_comb begin
    w_packetNext = '0;
    case (r_tagOp)
      TAG_INSTR: begin
        w_packetNext.id       = CORE_ID;
        w_packetNext.net_op   = NET_OP_INSTR;
        w_packetNext.net_data = {16'b0, instr_data_i};
        w_packetNext.net_addr = r_tagIdx;
      end
      TAG_REG: begin
        w_packetNext.id       = CORE_ID;
        w_packetNext.net_op   = NET_OP_REG;
        w_packetNext.net_data = reg_data_i[31:0];
        w_packetNext.net_addr = {4'b0, reg_data_i[37:32]};
      end
      TAG_BAR: begin
        w_packetNext.id       = CORE_ID;
        w_packetNext.net_op   = NET_OP_BAR;
        w_packetNext.net_data = BAR_MASK;
        w_packetNext.net_addr = BAR_ADDR;
      end
      TAG_PC: begin
        w_packetNext.id       = CORE_ID;
        w_packetNext.net_op   = NET_OP_PC;
        w_packetNext.net_data = START_PC;
        w_packetNext.net_addr = '0;
      end
      TAG_IDLE: begin
        w_packetNext.id       = CORE_ID;
        w_packetNext.net_op   = NET_OP_NULL;
        w_packetNext.net_data = IDLE_DATA;
        w_packetNext.net_addr = BAR_ADDR;
      end
      default: begin
        w_packetNext = '0;
      end
    endcase
  end

  // Flags flip together with the first idle packet reaching the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_packet <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_packet <= w_packetNext;
      if (r_state == S_IDLE && start_i) begin
        r_busy <= 1'b1;
      end
      if (r_tagOp == TAG_IDLE) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign w_unusedRegBits   = ^reg_data_i[39:38];
  assign instr_addr_o      = r_instrCnt;
  assign reg_addr_o        = r_regCnt;
  assign net_packet_flat_o = r_packet;
  assign busy_o            = r_busy;
  assign done_o            = r_done;

endmodule
